// File: rtl/preamble_generator.sv
// -----------------------------------------------------------------------------
// preamble_generator
// Streams one training preamble per accepted start: 16*STS_REPS short-symbol
// samples, then an LTS_GI-sample guard interval, then 64*LTS_REPS long-symbol
// samples. Every I/Q component is arithmetic-right-shifted by a scale latched
// at start.
//
// Parameters
//   STS_REPS  number of 16-sample short training symbols
//   LTS_GI    LTS guard-interval length in samples (0..64)
//   LTS_REPS  number of 64-sample long training symbols (>= 1)
// Ports
//   clk_in, rstn_in        clock, asynchronous active-low reset
//   start_in               single-cycle request for one preamble
//   scale_in               right-shift amount, latched on accepted start
//   busy_out, done_out     frame in progress / one-cycle end-of-frame pulse
//   preamble_axis_*        AXI-Stream master, tdata = {I[31:16], Q[15:0]}
// -----------------------------------------------------------------------------
module preamble_generator #(
   parameter int unsigned STS_REPS = 10,
   parameter int unsigned LTS_GI   = 32,
   parameter int unsigned LTS_REPS = 2
) (
   input  logic        clk_in,
   input  logic        rstn_in,
   input  logic        start_in,
   input  logic [1:0]  scale_in,
   output logic        busy_out,
   output logic        done_out,
   output logic        preamble_axis_tvalid,
   input  logic        preamble_axis_tready,
   output logic        preamble_axis_tlast,
   output logic [31:0] preamble_axis_tdata
);

   localparam int unsigned StsLen = 16 * STS_REPS;
   localparam int unsigned LtsLen = 64 * LTS_REPS;

   typedef enum logic [2:0] {StIdle, StSts, StGi, StLts, StDone} state_e;

   localparam state_e FirstSt = (STS_REPS != 0) ? StSts : (LTS_GI != 0) ? StGi : StLts;
   localparam state_e AfterSts = (LTS_GI != 0) ? StGi : StLts;

   // ROM contents are generated arithmetically so the block is self-contained.
   function automatic logic [31:0] sts_rom(input logic [3:0] a);
      return {16'(32'(a) * 32'd2311 + 32'd1000), 16'(32'd500 - 32'(a) * 32'd4099)};
   endfunction

   function automatic logic [31:0] lts_rom(input logic [5:0] a);
      return {16'(32'(a) * 32'd517 - 32'd5), 16'(32'd8 - 32'(a) * 32'd301)};
   endfunction

   // Sample for (state, index) after scaling; shifts floor toward -inf.
   function automatic logic [31:0] fetch(input state_e st, input logic [15:0] idx,
                                         input logic [1:0] sc);
      logic [31:0] raw;
      case (st)
         StSts:   raw = sts_rom(idx[3:0]);
         StGi:    raw = lts_rom(6'(64 - LTS_GI + 32'(idx)));
         StLts:   raw = lts_rom(idx[5:0]);
         default: raw = '0;
      endcase
      return {$signed(raw[31:16]) >>> sc, $signed(raw[15:0]) >>> sc};
   endfunction

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  scale_q, scale_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic [31:0] tdata_q, tdata_d;
   logic [1:0]  rst_sync_q;
   logic        start_ok;

   state_e      nxt_state;
   logic [15:0] nxt_cnt;
   logic        load;

   // Release of reset is synchronised; starts are held off until it has propagated.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign start_ok = rst_sync_q[1];

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         scale_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         scale_q  <= scale_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
      end
   end

   // state_q/cnt_q name the sample currently presented; on each handshake the
   // following sample is computed and loaded so there is never a bubble.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      scale_d   = scale_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tdata_d   = tdata_q;
      nxt_state = state_q;
      nxt_cnt   = cnt_q;
      load      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_in && start_ok) begin
               scale_d   = scale_in;
               nxt_state = FirstSt;
               nxt_cnt   = '0;
               load      = 1'b1;
            end
         end
         StSts, StGi, StLts: begin
            if (tvalid_q && preamble_axis_tready) begin
               if (tlast_q) begin
                  state_d  = StDone;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
               end else begin
                  load = 1'b1;
                  if (state_q == StSts && cnt_q == 16'(StsLen - 1)) begin
                     nxt_state = AfterSts;
                     nxt_cnt   = '0;
                  end else if (state_q == StGi && cnt_q == 16'(LTS_GI - 1)) begin
                     nxt_state = StLts;
                     nxt_cnt   = '0;
                  end else begin
                     nxt_cnt = cnt_q + 16'd1;
                  end
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (load) begin
         state_d  = nxt_state;
         cnt_d    = nxt_cnt;
         tvalid_d = 1'b1;
         tlast_d  = (nxt_state == StLts) && (nxt_cnt == 16'(LtsLen - 1));
         tdata_d  = fetch(nxt_state, nxt_cnt, scale_d);
      end
   end

   assign busy_out             = (state_q == StSts) || (state_q == StGi) || (state_q == StLts);
   assign done_out             = (state_q == StDone);
   assign preamble_axis_tvalid = tvalid_q;
   assign preamble_axis_tlast  = tlast_q;
   assign preamble_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_preamble_generator.sv
module tb_preamble_generator;

   logic        clk = 1'b0;
   logic        rstn, start, ready, busy, done, tvalid, tlast;
   logic [1:0]  scale;
   logic [31:0] tdata;
   logic        start_b, busy_b, done_b, tvalid_b, tlast_b;
   logic [31:0] tdata_b;

   always #5 clk = ~clk;

   preamble_generator dut (
      .clk_in               (clk),
      .rstn_in              (rstn),
      .start_in             (start),
      .scale_in             (scale),
      .busy_out             (busy),
      .done_out             (done),
      .preamble_axis_tvalid (tvalid),
      .preamble_axis_tready (ready),
      .preamble_axis_tlast  (tlast),
      .preamble_axis_tdata  (tdata)
   );

   preamble_generator #(.STS_REPS(0), .LTS_GI(0), .LTS_REPS(2)) dut_b (
      .clk_in               (clk),
      .rstn_in              (rstn),
      .start_in             (start_b),
      .scale_in             (2'd0),
      .busy_out             (busy_b),
      .done_out             (done_b),
      .preamble_axis_tvalid (tvalid_b),
      .preamble_axis_tready (ready),
      .preamble_axis_tlast  (tlast_b),
      .preamble_axis_tdata  (tdata_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference ROM model and scaling
   function automatic int sx16(input int v);
      int m;
      m = v & 'hFFFF;
      return (m >= 32768) ? m - 65536 : m;
   endfunction

   function automatic int floor_shift(input int v, input int sc);
      int d;
      d = 1 << sc;
      return (v >= 0) ? v / d : -((-v + d - 1) / d);
   endfunction

   function automatic logic [31:0] pack(input int i, input int q, input int sc);
      logic [15:0] a, b;
      a = 16'(floor_shift(i, sc));
      b = 16'(floor_shift(q, sc));
      return {a, b};
   endfunction

   function automatic logic [31:0] sts_ref(input int a, input int sc);
      return pack(sx16(a * 2311 + 1000), sx16(500 - a * 4099), sc);
   endfunction

   function automatic logic [31:0] lts_ref(input int a, input int sc);
      return pack(sx16(a * 517 - 5), sx16(8 - a * 301), sc);
   endfunction

   function automatic logic [32:0] exp_sample(input int n, input int sc, input int sr,
                                              input int gi, input int lr);
      int total;
      logic [31:0] d;
      total = 16 * sr + gi + 64 * lr;
      if (n < 16 * sr)           d = sts_ref(n % 16, sc);
      else if (n < 16 * sr + gi) d = lts_ref(64 - gi + (n - 16 * sr), sc);
      else                       d = lts_ref((n - 16 * sr - gi) % 64, sc);
      return {(n == total - 1), d};
   endfunction

   // Ready generator
   bit rand_ready = 0;
   initial ready = 1'b1;
   always @(posedge clk) begin
      #1;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Scoreboard and monitor for the default build
   logic [32:0] qa[$];
   logic [32:0] ea, held;
   int          hs_a = 0, done_a = 0, cyc = 0, first_hs = 0, last_hs = 0;
   int          cap_idx = -1;
   logic [31:0] cap_data = '0;
   bit          stall_pend = 0, prev_last = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         stall_pend = 0;
         prev_last  = 0;
      end else begin
         if (stall_pend) begin
            check("stall_valid", tvalid, 1);
            check("stall_hold", {tlast, tdata}, held);
         end
         if (tvalid && ready) begin
            if (qa.size() == 0) check("extra_sample", {tlast, tdata}, 0);
            else begin
               ea = qa.pop_front();
               check("sample", {tlast, tdata}, ea);
            end
            if (hs_a == 0) first_hs = cyc;
            last_hs = cyc;
            if (hs_a == cap_idx) cap_data = tdata;
            hs_a++;
            prev_last = tlast;
         end else begin
            if (prev_last) begin
               check("done_pulse", {done, busy, tvalid}, 3'b100);
               done_a++;
            end else check("no_done", done, 0);
            prev_last = 0;
         end
         stall_pend = tvalid && !ready;
         held       = {tlast, tdata};
      end
   end

   // Scoreboard for the STS_REPS=0, LTS_GI=0 build
   logic [32:0] qb[$];
   logic [32:0] eb;
   int          hs_b = 0, done_bc = 0;

   always @(negedge clk) begin
      if (rstn && tvalid_b && ready) begin
         if (qb.size() == 0) check("b_extra_sample", {tlast_b, tdata_b}, 0);
         else begin
            eb = qb.pop_front();
            check("b_sample", {tlast_b, tdata_b}, eb);
         end
         hs_b++;
      end
      if (rstn && done_b) done_bc++;
   end

   task automatic push_frame(input int sc);
      for (int n = 0; n < 320; n++) qa.push_back(exp_sample(n, sc, 10, 32, 2));
   endtask

   task automatic pulse_start(input logic [1:0] sc);
      @(posedge clk); #1;
      scale = sc;
      start = 1'b1;
      @(negedge clk);
      check("pre_valid", tvalid, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("first_valid_busy", {tvalid, busy}, 2'b11);
   endtask

   task automatic wait_frame(input int target, input int limit);
      int n;
      n = 0;
      while (done_a < target && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      check("frame_timeout", done_a >= target, 1);
   endtask

   task automatic wait_hs(input int target);
      int n;
      n = 0;
      while (hs_a < target && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      check("hs_timeout", hs_a >= target, 1);
   endtask

   initial begin
      int n;
      rstn    = 1'b0;
      start   = 1'b0;
      start_b = 1'b0;
      scale   = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {busy, done, tvalid, tlast}, 4'b0000);
      check("reset_tdata", tdata, 0);
      check("reset_ctrl_b", {busy_b, done_b, tvalid_b, tlast_b}, 4'b0000);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (3) @(posedge clk);

      // Contiguous frame with tready high
      hs_a = 0;
      push_frame(0);
      pulse_start(2'd0);
      wait_frame(1, 2000);
      check("count_t1", hs_a, 320);
      check("contiguous", last_hs - first_hs, 319);
      check("queue_empty_t1", qa.size(), 0);

      // Random backpressure plus a second start mid-frame
      rand_ready = 1;
      hs_a = 0;
      push_frame(0);
      pulse_start(2'd0);
      wait_hs(100);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_frame(2, 5000);
      check("count_t2", hs_a, 320);
      check("queue_empty_t2", qa.size(), 0);

      // Scale 2, started the cycle after done; scale change mid-frame ignored
      rand_ready = 0;
      hs_a = 0;
      cap_idx = 192;
      push_frame(2);
      pulse_start(2'd2);
      repeat (5) @(posedge clk);
      #1 scale = 2'd0;
      wait_frame(3, 2000);
      check("sample192", cap_data, {16'hFFFE, 16'h0002});
      check("queue_empty_t3", qa.size(), 0);
      cap_idx = -1;

      // Reset mid-frame
      hs_a = 0;
      push_frame(0);
      pulse_start(2'd0);
      wait_hs(200);
      @(posedge clk); #2;
      check("valid_before_rst", tvalid, 1);
      rstn = 1'b0;
      #1;
      check("rst_async_ctrl", {tvalid, busy, done, tlast}, 4'b0000);
      check("rst_async_tdata", tdata, 0);
      qa.delete();
      repeat (2) @(posedge clk);
      #1;
      rstn  = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("early_start_ignored", {tvalid, busy}, 2'b00);
      repeat (3) @(posedge clk);
      check("no_done_after_abandon", done_a, 3);
      hs_a = 0;
      push_frame(0);
      pulse_start(2'd0);
      wait_frame(4, 2000);
      check("count_t4", hs_a, 320);
      check("queue_empty_t4", qa.size(), 0);

      // STS_REPS=0, LTS_GI=0 build
      for (int k = 0; k < 128; k++) qb.push_back(exp_sample(k, 0, 0, 0, 2));
      @(posedge clk); #1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      n = 0;
      while (done_bc < 1 && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      check("b_timeout", done_bc >= 1, 1);
      check("b_count", hs_b, 128);
      check("b_queue_empty", qb.size(), 0);
      check("a_idle", {busy, tvalid}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
